pwm_meter: RTL

Bus-mapped PWM capture peripheral that sits directly downstream of the `pwm` generator. It samples a PWM waveform (the generator's `pwmOutput`, looped back or taken from a pin) and measures period and high time in `clk` cycles. It exposes status and measurement registers on the same single-cycle select/write bus used by the other CPU peripherals, which lets firmware and benches close the loop on the generator's compare value.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_sync_edge.sv | 32 +++
 rtl/pwm_meter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture peripheral: register indices,
// CTRL/STATUS bit positions, FSM encoding and the default counter width.
package pwm_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_HIGH   = 2'd2;
  localparam logic [1:0] REG_EDGES  = 2'd3;

  localparam int BIT_EN    = 0;
  localparam int BIT_IE    = 1;
  localparam int BIT_VALID = 8;
  localparam int BIT_OVF   = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEAS_HI = 2'd2,
    ST_MEAS_LO = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for the asynchronous PWM input followed by a
// one-flop edge detector; rise/fall are single-cycle pulses.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   lvl_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      lvl_p1  <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig};
      lvl_p1  <= sync_p0[SYNC_STAGES-1];
    end
  end

  // Edge pulses compare the synchronized level against its one-cycle delay.
  assign lvl  = sync_p0[SYNC_STAGES-1];
  assign rise = lvl & ~lvl_p1;
  assign fall = ~lvl & lvl_p1;

endmodule

// File: rtl/pwm_meter.sv
// PWM capture peripheral: measures period and high time of pwmIn in clk
// cycles and exposes CTRL/STATUS, PERIOD, HIGH and EDGES on a simple bus.
module pwm_meter
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bSel,
  input  logic        bWrite,
  input  logic [1:0]  bAddr,
  input  logic [31:0] bWData,
  output logic [31:0] bRData,
  input  logic        pwmIn,
  output logic        irq
);

  // A measurement aborts one count before the counter would hit all-ones.
  function automatic logic at_limit(input logic [CNT_W-1:0] c);
    return c == ({CNT_W{1'b1}} - CNT_W'(1));
  endfunction

  logic             lvl, rise, fall;
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] hi_shadow, hi_next;
  logic [CNT_W-1:0] period, high, edges;
  logic             en, ie, valid, ovf;
  logic             ctrl_wr, en_next, commit, sat;
  logic             unused_bits;

  pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .sig  (pwmIn),
    .lvl  (lvl),
    .rise (rise),
    .fall (fall)
  );

  assign unused_bits = ^{lvl, bWData[31:10], bWData[7:2]};
  assign ctrl_wr     = bSel && bWrite && (bAddr == REG_CTRL);
  // Looking at the written enable lets a disable win over a same-cycle commit.
  assign en_next     = ctrl_wr ? bWData[BIT_EN] : en;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    hi_next    = hi_shadow;
    commit     = 1'b0;
    sat        = 1'b0;
    if (!en_next) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      hi_next    = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_next = ST_ARM;
          cnt_next   = '0;
        end
        ST_ARM: begin
          if (rise) begin
            state_next = ST_MEAS_HI;
            cnt_next   = CNT_W'(1);
          end
        end
        ST_MEAS_HI: begin
          if (at_limit(cnt)) begin
            sat        = 1'b1;
            state_next = ST_ARM;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
            if (fall) begin
              hi_next    = cnt;
              state_next = ST_MEAS_LO;
            end
          end
        end
        ST_MEAS_LO: begin
          if (at_limit(cnt)) begin
            sat        = 1'b1;
            state_next = ST_ARM;
            cnt_next   = '0;
          end else if (rise) begin
            commit     = 1'b1;
            cnt_next   = CNT_W'(1);
            state_next = ST_MEAS_HI;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hi_shadow <= '0;
      en        <= 1'b0;
      ie        <= 1'b0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
      period    <= '0;
      high      <= '0;
      edges     <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      hi_shadow <= hi_next;
      if (ctrl_wr) begin
        en <= bWData[BIT_EN];
        ie <= bWData[BIT_IE];
      end
      // Flag set has priority over a write-1-to-clear in the same cycle.
      valid <= commit | (valid & ~(ctrl_wr & bWData[BIT_VALID]));
      ovf   <= sat    | (ovf   & ~(ctrl_wr & bWData[BIT_OVF]));
      if (commit) begin
        period <= cnt;
        high   <= hi_shadow;
      end
      if (ctrl_wr && bWData[BIT_EN] && !en) edges <= '0;
      else if (commit)                      edges <= edges + CNT_W'(1);
    end
  end

  always_comb begin
    bRData = '0;
    if (bSel) begin
      unique case (bAddr)
        REG_CTRL: begin
          bRData[BIT_EN]    = en;
          bRData[BIT_IE]    = ie;
          bRData[BIT_VALID] = valid;
          bRData[BIT_OVF]   = ovf;
        end
        REG_PERIOD: bRData = 32'(period);
        REG_HIGH:   bRData = 32'(high);
        REG_EDGES:  bRData = 32'(edges);
        default:    bRData = '0;
      endcase
    end
  end

  assign irq = valid && ie;

endmodule
